// File: rtl/cromatic_ctrl.sv
// cromatic_ctrl: button debounce, colour-advance sequencing (manual/auto)
// and a glitch-free PWM brightness controller for an RGB colour datapath.
//
// state  | meaning
// MANUAL | colour advances only on btn_n presses
// AUTO   | colour also advances every AUTO_CYCLES clocks
module cromatic_ctrl #(
  parameter int DEB_CYCLES  = 50000,
  parameter int PWM_BITS    = 8,
  parameter int STEP        = 16,
  parameter int AUTO_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_n,
  input  logic              up_n,
  input  logic              dn_n,
  input  logic              auto_en,
  output logic              f_edge,
  output logic              pwm_out,
  output logic [2:0]        color_idx,
  output logic [PWM_BITS:0] duty
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);
  localparam logic [PWM_BITS:0] FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PWM_BITS:0] STEP_V = (PWM_BITS + 1)'(STEP);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

  // Button index: 0 = colour advance, 1 = brightness up, 2 = brightness down.
  logic [2:0]          raw;
  logic [2:0]          sync1;
  logic [2:0]          sync2;
  logic [2:0]          lvl;
  logic [2:0]          lvl_d;
  logic [2:0]          press;
  logic [DW-1:0]       deb_cnt [3];

  mode_t               state;
  mode_t               next_state;
  logic [AW-1:0]       auto_cnt;
  logic                auto_tc;
  logic                auto_clr;

  logic [PWM_BITS:0]   pend;
  logic [PWM_BITS:0]   pend_next;
  logic [PWM_BITS-1:0] pwm_cnt;

  assign raw   = {dn_n, up_n, btn_n};
  // A press is the cycle after a debounced level falls; releases are ignored.
  assign press = lvl_d & ~lvl;

  // Two-flop synchronizers followed by per-button stability counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      lvl   <= '1;
      lvl_d <= '1;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_d <= lvl;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          // The DEB_CYCLES-th consecutive differing sample flips the level.
          deb_cnt[i] <= '0;
          lvl[i]     <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) state <= MANUAL;
    else     state <= next_state;
  end

  // Mode next-state logic plus auto-advance terminal count and counter clear.
  always_comb begin
    next_state = state;
    case (state)
      MANUAL:  if (auto_en)  next_state = AUTO;
      AUTO:    if (!auto_en) next_state = MANUAL;
      default: next_state = MANUAL;
    endcase
    auto_tc  = (state == AUTO) && (auto_cnt == AUTO_LAST);
    auto_clr = (next_state != state) || press[0] || auto_tc;
  end

  // Auto-advance interval counter, restarted by mode changes and presses.
  always_ff @(posedge clk) begin
    if (rst)                 auto_cnt <= '0;
    else if (auto_clr)       auto_cnt <= '0;
    else if (state == AUTO)  auto_cnt <= auto_cnt + 1'b1;
  end

  // Colour-advance pulse; a press and a terminal count together give one pulse,
  // and the feedback term keeps the pulse from ever lasting two cycles.
  always_ff @(posedge clk) begin
    if (rst) f_edge <= 1'b0;
    else     f_edge <= (press[0] | auto_tc) & ~f_edge;
  end

  // Colour index mirrors the datapath, cycling through 0..6.
  always_ff @(posedge clk) begin
    if (rst)          color_idx <= 3'd0;
    else if (f_edge)  color_idx <= (color_idx == 3'd6) ? 3'd0 : color_idx + 3'd1;
  end

  // Saturating pending-duty update; simultaneous up and down cancel.
  always_comb begin
    pend_next = pend;
    if (press[1] && !press[2]) begin
      pend_next = ((FULL - pend) < STEP_V) ? FULL : pend + STEP_V;
    end else if (press[2] && !press[1]) begin
      pend_next = (pend < STEP_V) ? '0 : pend - STEP_V;
    end
  end

  // Pending duty register.
  always_ff @(posedge clk) begin
    if (rst) pend <= FULL;
    else     pend <= pend_next;
  end

  // Free-running PWM; the active duty only changes at the counter wrap so a
  // period is never cut short or stretched by a mid-period update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= FULL;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) duty <= pend;
      pwm_out <= ({1'b0, pwm_cnt} >= duty);
    end
  end

endmodule

// File: tb/tb_cromatic_ctrl.sv
// Directed bench for cromatic_ctrl with small parameters.
module tb_cromatic_ctrl;

  localparam int DEB  = 4;
  localparam int PB   = 3;
  localparam int STP  = 2;
  localparam int AUTO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_n = 1'b1;
  logic        up_n = 1'b1;
  logic        dn_n = 1'b1;
  logic        auto_en = 1'b0;
  logic        f_edge;
  logic        pwm_out;
  logic [2:0]  color_idx;
  logic [PB:0] duty;

  int checks = 0;
  int errors = 0;

  cromatic_ctrl #(
    .DEB_CYCLES (DEB),
    .PWM_BITS   (PB),
    .STEP       (STP),
    .AUTO_CYCLES(AUTO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .up_n     (up_n),
    .dn_n     (dn_n),
    .auto_en  (auto_en),
    .f_edge   (f_edge),
    .pwm_out  (pwm_out),
    .color_idx(color_idx),
    .duty     (duty)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // which: 0 colour, 1 up, 2 down, 3 up+down together
  task automatic press(input int which);
    @(negedge clk);
    if (which == 0) btn_n = 1'b0;
    if (which == 1 || which == 3) up_n = 1'b0;
    if (which == 2 || which == 3) dn_n = 1'b0;
    repeat (10) @(negedge clk);
    btn_n = 1'b1;
    up_n  = 1'b1;
    dn_n  = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic count_pwm(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_out) ones++;
    end
  endtask

  initial begin
    int ones;
    int exp_dn [5] = '{6, 4, 2, 0, 0};
    int exp_up [5] = '{2, 4, 6, 8, 8};

    // reset values
    repeat (2) @(negedge clk);
    check_val("rst_f_edge", f_edge, 0);
    check_val("rst_color", color_idx, 0);
    check_val("rst_duty", duty, 8);
    check_val("rst_pwm", pwm_out, 0);
    rst = 1'b0;

    // held press: single pulse 7 cycles after the falling edge
    @(negedge clk);
    btn_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check_val($sformatf("press_f_edge_%0d", i), f_edge, (i == 7));
    end
    btn_n = 1'b1;
    repeat (12) @(negedge clk);
    check_val("press_color", color_idx, 1);

    // 3-cycle glitch is rejected
    btn_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check_val($sformatf("glitch_f_edge_%0d", i), f_edge, 0);
    end
    check_val("glitch_color", color_idx, 1);

    // brightness from reset
    do_reset();
    for (int k = 0; k < 5; k++) begin
      press(2);
      check_val($sformatf("dn_duty_%0d", k), duty, exp_dn[k]);
      if (k == 2) begin
        count_pwm(16, ones);
        check_val("pwm_duty2_ones", ones, 12);
      end
    end
    count_pwm(16, ones);
    check_val("pwm_duty0_ones", ones, 16);
    for (int k = 0; k < 5; k++) begin
      press(1);
      check_val($sformatf("up_duty_%0d", k), duty, exp_up[k]);
    end
    count_pwm(16, ones);
    check_val("pwm_duty8_ones", ones, 0);
    press(2);
    check_val("dn_after_full", duty, 6);
    press(3);
    check_val("up_dn_same_cycle", duty, 6);
    check_val("duty_color_untouched", color_idx, 0);

    // seven colour presses wrap 6 -> 0
    for (int k = 1; k <= 7; k++) begin
      press(0);
      check_val($sformatf("seq_color_%0d", k), color_idx, k % 7);
    end

    // auto mode: pulses every 20 cycles
    auto_en = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      @(negedge clk);
      check_val($sformatf("auto_f_edge_%0d", i), f_edge, (i == 21 || i == 41 || i == 61));
    end
    auto_en = 1'b0;
    repeat (5) @(negedge clk);
    check_val("auto_color", color_idx, 3);

    // press coinciding with terminal count, then a press that restarts the count
    auto_en = 1'b1;
    for (int i = 1; i <= 62; i++) begin
      @(negedge clk);
      check_val($sformatf("coinc_f_edge_%0d", i), f_edge, (i == 21 || i == 37 || i == 57));
      if (i == 14) btn_n = 1'b0;
      if (i == 22) btn_n = 1'b1;
      if (i == 30) btn_n = 1'b0;
      if (i == 40) btn_n = 1'b1;
    end
    auto_en = 1'b0;
    repeat (5) @(negedge clk);
    check_val("coinc_color", color_idx, 6);

    // reset mid-debounce and mid-auto-count
    auto_en = 1'b1;
    repeat (8) @(negedge clk);
    btn_n = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_f_edge", f_edge, 0);
    check_val("midrst_color", color_idx, 0);
    check_val("midrst_duty", duty, 8);
    check_val("midrst_pwm", pwm_out, 0);
    rst   = 1'b0;
    btn_n = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      check_val($sformatf("post_rst_f_edge_%0d", i), f_edge, (i == 21));
    end
    auto_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
